// File: rtl/if_stage_if.sv
//------------------------------------------------------------------------------
// Module     : if_stage_if
// Description: Fetch-stage bus bundle: decode handshake, branch redirect input
//              and the synchronous instruction SRAM port.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface if_stage_if;
    logic        ds_allowin;
    logic [32:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    // Fetch stage side
    modport master (
        input  ds_allowin,
        input  br_bus,
        input  inst_sram_rdata,
        output fs_to_ds_valid,
        output fs_to_ds_bus,
        output inst_sram_en,
        output inst_sram_wen,
        output inst_sram_addr,
        output inst_sram_wdata
    );

    // Decode stage / memory side
    modport slave (
        output ds_allowin,
        output br_bus,
        output inst_sram_rdata,
        input  fs_to_ds_valid,
        input  fs_to_ds_bus,
        input  inst_sram_en,
        input  inst_sram_wen,
        input  inst_sram_addr,
        input  inst_sram_wdata
    );
endinterface

`default_nettype wire

// File: rtl/if_stage.sv
//------------------------------------------------------------------------------
// Module     : if_stage
// Description: MIPS fetch stage - PC, instruction SRAM request, decode stall
//              hold buffer and delay-slot branch redirect buffer.
//              Optional macro IF_PERF_CNT_EN adds fetch/stall counters.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  wire logic   clk,
    input  wire logic   reset,
    if_stage_if.master  fs_if
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fs_fetch_cnt,
    output logic [31:0] fs_stall_cnt
`endif
);

    localparam logic [31:0] c_pc_init = RESET_PC - 32'd4;

    logic        r_fs_valid;
    logic [31:0] r_fs_pc;
    logic        r_buf_valid;
    logic [31:0] r_inst_buf;
    logic        r_br_pend;
    logic [31:0] r_br_buf;

    logic        w_to_fs_valid;
    logic        w_fs_ready_go;
    logic        w_fs_allowin;
    logic        w_fs_to_ds_valid;
    logic        w_sram_en;
    logic        w_br_taken;
    logic [31:0] w_br_target;
    logic [31:0] w_seq_pc;
    logic [31:0] w_nextpc;
    logic [31:0] w_fs_inst;
    logic        w_ds_accept;

    // pre-IF: next PC selection; a buffered redirect has priority over a live one
    assign w_to_fs_valid = ~reset;
    assign w_br_taken    = fs_if.br_bus[32];
    assign w_br_target   = fs_if.br_bus[31:0];
    assign w_seq_pc      = r_fs_pc + 32'd4;
    assign w_nextpc      = r_br_pend  ? r_br_buf    :
                           w_br_taken ? w_br_target : w_seq_pc;

    assign w_fs_ready_go    = 1'b1;
    assign w_fs_allowin     = ~r_fs_valid | (w_fs_ready_go & fs_if.ds_allowin);
    assign w_fs_to_ds_valid = r_fs_valid & w_fs_ready_go;
    assign w_sram_en        = w_to_fs_valid & w_fs_allowin;
    assign w_ds_accept      = w_fs_to_ds_valid & fs_if.ds_allowin;

    // SRAM data is only valid the cycle after the request; stalls read the copy
    assign w_fs_inst = r_buf_valid ? r_inst_buf : fs_if.inst_sram_rdata;

    assign fs_if.fs_to_ds_valid  = w_fs_to_ds_valid;
    assign fs_if.fs_to_ds_bus    = {r_fs_pc, w_fs_inst};
    assign fs_if.inst_sram_en    = w_sram_en;
    assign fs_if.inst_sram_wen   = 4'h0;
    assign fs_if.inst_sram_addr  = w_nextpc;
    assign fs_if.inst_sram_wdata = 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fs_valid <= 1'b0;
            r_fs_pc    <= c_pc_init;
        end else if (w_fs_allowin) begin
            r_fs_valid <= w_to_fs_valid;
            if (w_to_fs_valid) begin
                r_fs_pc <= w_nextpc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_valid <= 1'b0;
            r_inst_buf  <= 32'h0;
        end else if (w_ds_accept) begin
            r_buf_valid <= 1'b0;
        end else if (r_fs_valid & ~fs_if.ds_allowin & ~r_buf_valid) begin
            r_inst_buf  <= fs_if.inst_sram_rdata;
            r_buf_valid <= 1'b1;
        end
    end

    // Only the first redirect of a stall is kept; later held copies are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            r_br_pend <= 1'b0;
            r_br_buf  <= 32'h0;
        end else if (w_sram_en) begin
            r_br_pend <= 1'b0;
        end else if (w_br_taken & ~r_br_pend) begin
            r_br_buf  <= w_br_target;
            r_br_pend <= 1'b1;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_cnt <= 32'h0;
            r_stall_cnt <= 32'h0;
        end else begin
            if (w_ds_accept) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (r_fs_valid & ~fs_if.ds_allowin) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign fs_fetch_cnt = r_fetch_cnt;
    assign fs_stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
//------------------------------------------------------------------------------
// Module     : tb_if_stage
// Description: Scoreboard bench for if_stage (define IF_PERF_CNT_EN for counters).
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_if_stage;

    localparam logic [31:0] c_base = 32'hBFC00000;

    logic clk;
    logic reset;

    if_stage_if u_if ();

`ifdef IF_PERF_CNT_EN
    logic [31:0] fs_fetch_cnt;
    logic [31:0] fs_stall_cnt;
`endif

    if_stage #(.RESET_PC(c_base)) u_dut (
        .clk   (clk),
        .reset (reset),
        .fs_if (u_if)
`ifdef IF_PERF_CNT_EN
        ,
        .fs_fetch_cnt (fs_fetch_cnt),
        .fs_stall_cnt (fs_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_bus_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Memory word k holds k; idle cycles return junk so a missing hold shows up
    always @(posedge clk) begin
        if (u_if.inst_sram_en)
            u_if.inst_sram_rdata <= (u_if.inst_sram_addr - c_base) >> 2;
        else
            u_if.inst_sram_rdata <= 32'hDEADBEEF;
    end

    // Monitor: pops expectations on every request and every accepted transfer
    always @(negedge clk) begin
        if (u_if.inst_sram_en) begin
            if (exp_addr_q.size() == 0) begin
                n_checks++;
                $display("FAIL sram_addr: unexpected request %h", u_if.inst_sram_addr);
            end else begin
                check("sram_addr", {32'h0, u_if.inst_sram_addr}, {32'h0, exp_addr_q.pop_front()});
            end
        end
        if (u_if.fs_to_ds_valid && u_if.ds_allowin) begin
            if (exp_bus_q.size() == 0) begin
                n_checks++;
                $display("FAIL fs_to_ds_bus: unexpected transfer %h", u_if.fs_to_ds_bus);
            end else begin
                check("fs_to_ds_bus", u_if.fs_to_ds_bus, exp_bus_q.pop_front());
            end
        end
    end

    task automatic drive(input logic rst_v, input logic allow, input logic [32:0] br);
        @(posedge clk);
        #1;
        reset           = rst_v;
        u_if.ds_allowin = allow;
        u_if.br_bus     = br;
        @(negedge clk);
    endtask

    function automatic logic [63:0] bus_of(input logic [31:0] pc, input logic [31:0] k);
        return {pc, k};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    logic [63:0] held_bus;

    initial begin
        reset           = 1'b1;
        u_if.ds_allowin = 1'b1;
        u_if.br_bus     = 33'h0;

        // Expected requests and transfers, hand-computed
        exp_addr_q = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008,
                       32'hBFC00100, 32'hBFC00104,
                       32'hBFC00200, 32'hBFC00204};
        exp_bus_q  = '{bus_of(32'hBFC00000, 32'd0),    bus_of(32'hBFC00004, 32'd1),
                       bus_of(32'hBFC00008, 32'd2),    bus_of(32'hBFC00100, 32'h40),
                       bus_of(32'hBFC00104, 32'h41),   bus_of(32'hBFC00200, 32'h80)};
        for (int k = 0; k <= 10; k++) exp_addr_q.push_back(c_base + 32'(4 * k));
        for (int k = 0; k <= 9; k++)  exp_bus_q.push_back(bus_of(c_base + 32'(4 * k), 32'(k)));

        drive(1'b1, 1'b1, 33'h0);
        check("reset fs_to_ds_valid", {63'h0, u_if.fs_to_ds_valid}, 64'h0);
        check("reset inst_sram_en",   {63'h0, u_if.inst_sram_en},   64'h0);
        check("inst_sram_wen tie",    {60'h0, u_if.inst_sram_wen},  64'h0);
        check("inst_sram_wdata tie",  {32'h0, u_if.inst_sram_wdata}, 64'h0);
        drive(1'b1, 1'b1, 33'h0);
        drive(1'b1, 1'b1, 33'h0);

        // Streaming start
        drive(1'b0, 1'b1, 33'h0);
        check("first fs_to_ds_valid", {63'h0, u_if.fs_to_ds_valid}, 64'h0);
        drive(1'b0, 1'b1, 33'h0);
        drive(1'b0, 1'b1, 33'h0);

        // Three-cycle decode stall while BFC00008 sits in IF
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 33'h0);
            check("stall inst_sram_en", {63'h0, u_if.inst_sram_en}, 64'h0);
            check("stall fs_to_ds_bus", u_if.fs_to_ds_bus, bus_of(32'hBFC00008, 32'd2));
            check("stall fs_to_ds_valid", {63'h0, u_if.fs_to_ds_valid}, 64'h1);
        end

        // Delay-slot redirect with decode accepting
        drive(1'b0, 1'b1, {1'b1, 32'hBFC00100});
        drive(1'b0, 1'b1, 33'h0);

        // Redirect during a stall is buffered; a later held value must not overwrite
        drive(1'b0, 1'b0, {1'b1, 32'hBFC00200});
        check("br stall inst_sram_en", {63'h0, u_if.inst_sram_en}, 64'h0);
        held_bus = u_if.fs_to_ds_bus;
        drive(1'b0, 1'b0, {1'b1, 32'hBFC00300});
        check("br stall bus stable", u_if.fs_to_ds_bus, held_bus);
        drive(1'b0, 1'b1, 33'h0);
        drive(1'b0, 1'b1, 33'h0);

        // Build up buf_valid and br_pend, then reset mid-stream
        drive(1'b0, 1'b0, {1'b1, 32'hBFC00400});
        drive(1'b1, 1'b0, 33'h0);
        drive(1'b0, 1'b1, 33'h0);
        check("post-reset fs_to_ds_valid", {63'h0, u_if.fs_to_ds_valid}, 64'h0);
        check("post-reset inst_sram_en",   {63'h0, u_if.inst_sram_en},   64'h1);
        check("post-reset inst_sram_addr", {32'h0, u_if.inst_sram_addr}, {32'h0, c_base});

        // Ten accepted instructions then four stall cycles
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 33'h0);
        for (int i = 0; i < 4; i++)  drive(1'b0, 1'b0, 33'h0);
        drive(1'b1, 1'b0, 33'h0);
`ifdef IF_PERF_CNT_EN
        check("fs_fetch_cnt", {32'h0, fs_fetch_cnt}, 64'd10);
        check("fs_stall_cnt", {32'h0, fs_stall_cnt}, 64'd4);
`endif
        drive(1'b1, 1'b1, 33'h0);

        check("addr queue drained", 64'(exp_addr_q.size()), 64'h0);
        check("bus queue drained",  64'(exp_bus_q.size()),  64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
